// File: rtl/countdown_pkg.sv
// Shared definitions for the countdown timer: the FSM state encoding.
// Auto-reload behaviour is selected elsewhere with COUNTDOWN_AUTO_RELOAD_EN.
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/countdown_core.sv
// Loadable, clamping, saturating-at-zero decrementer with zero/one detect.
// With COUNTDOWN_AUTO_RELOAD_EN it also keeps the reload register and a reload input.
module countdown_core #(
    parameter int N     = 8,
    parameter int WIDTH = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    input  logic             reload,
`endif
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             is_zero,
    output logic             is_one
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(N - 1);

    logic [WIDTH-1:0] clamped;

    always_comb begin
        clamped = load_val;
        if (32'(load_val) > 32'(N - 1)) begin
            clamped = MAX_VAL;
        end
    end

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload_val;

    // Reload priority sits just below load, so a terminal count restarts from the saved value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= '0;
            reload_val <= '0;
        end else if (load) begin
            count      <= clamped;
            reload_val <= clamped;
        end else if (reload) begin
            count      <= reload_val;
        end else if (dec && (count != '0)) begin
            count      <= count - WIDTH'(1);
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= clamped;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end
`endif

    assign is_zero = (count == '0);
    assign is_one  = (count == WIDTH'(1));

endmodule

// File: rtl/countdown_timer.sv
// Countdown timer: IDLE/RUN/DONE FSM with registered busy, tc and done flags.
// Define COUNTDOWN_AUTO_RELOAD_EN to reload and keep running on terminal count.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int N     = 8,
    parameter int WIDTH = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    state_t state;
    state_t next_state;
    logic   busy_next;
    logic   tc_next;
    logic   done_next;
    logic   is_zero;
    logic   is_one;
    logic   dec;
    logic   terminal;

    // load and stop outrank everything, so decrement and terminal only happen without them.
    assign dec      = (state == RUN) && !load && !stop && ce;
    assign terminal = dec && is_one;

    countdown_core #(
        .N     (N),
        .WIDTH (WIDTH)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (load_val),
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        .reload   (terminal),
`endif
        .dec      (dec),
        .count    (out),
        .is_zero  (is_zero),
        .is_one   (is_one)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            tc    <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= busy_next;
            tc    <= tc_next;
            done  <= done_next;
        end
    end

    always_comb begin
        next_state = state;
        if (load) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !is_zero) begin
                        next_state = RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        next_state = IDLE;
                    end else if (terminal) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                        next_state = RUN;
`else
                        next_state = DONE;
`endif
                    end
                end
                DONE: begin
                    if (stop) begin
                        next_state = IDLE;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // Flags are computed one cycle ahead and registered alongside the state.
    always_comb begin
        busy_next = (next_state == RUN);
        tc_next   = terminal;
        done_next = done;
        if (load) begin
            done_next = 1'b0;
        end else begin
            case (state)
                IDLE: done_next = 1'b0;
                RUN: begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                    done_next = 1'b0;
`else
                    done_next = terminal;
`endif
                end
                DONE: begin
                    if (stop) begin
                        done_next = 1'b0;
                    end
                end
                default: done_next = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer (N=8, WIDTH=4 so load_val=12 is representable).
// Covers both builds: with and without COUNTDOWN_AUTO_RELOAD_EN.
module tb_countdown_timer;

    localparam int N     = 8;
    localparam int WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic             ce;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             stop;
    logic [WIDTH-1:0] out;
    logic             busy;
    logic             tc;
    logic             done;

    int checks   = 0;
    int failures = 0;

    countdown_timer #(
        .N     (N),
        .WIDTH (WIDTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ce       (ce),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .stop     (stop),
        .out      (out),
        .busy     (busy),
        .tc       (tc),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic l, input logic [WIDTH-1:0] lv,
                                  input logic s, input logic sp, input logic c);
        load     = l;
        load_val = lv;
        start    = s;
        stop     = sp;
        ce       = c;
    endtask

    task automatic check_val(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic check_output(input string tag, input int exp_out, input int exp_busy,
                                input int exp_tc, input int exp_done);
        check_val({tag, ".out"},  int'(out),  exp_out);
        check_val({tag, ".busy"}, int'(busy), exp_busy);
        check_val({tag, ".tc"},   int'(tc),   exp_tc);
        check_val({tag, ".done"}, int'(done), exp_done);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        rst_n = 1'b0;
        apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        check_output("reset", 0, 0, 0, 0);
        rst_n = 1'b1;

        // Basic countdown from 5.
        apply_stimulus(1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
        tick();
        check_output("load5", 5, 0, 0, 0);
        apply_stimulus(1'b0, '0, 1'b1, 1'b0, 1'b1);
        tick();
        check_output("start5", 5, 1, 0, 0);
        apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 4; i >= 1; i--) begin
            tick();
            check_output("dec5", i, 1, 0, 0);
        end
        tick();
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        check_output("term5", 5, 1, 1, 0);
        tick();
        check_output("after5", 4, 1, 0, 0);
        apply_stimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);
        tick();
        check_output("stop5", 4, 0, 0, 0);
`else
        check_output("term5", 0, 0, 1, 1);
        tick();
        check_output("after5", 0, 0, 0, 1);
        apply_stimulus(1'b0, '0, 1'b1, 1'b0, 1'b1);
        tick();
        check_output("done_start", 0, 0, 0, 1);
        apply_stimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
        tick();
        check_output("done_stop", 0, 0, 0, 0);
`endif

        // Clamp: 12 becomes 7, then seven enabled cycles to terminal.
        apply_stimulus(1'b1, 4'd12, 1'b0, 1'b0, 1'b0);
        tick();
        check_output("clamp", 7, 0, 0, 0);
        apply_stimulus(1'b0, '0, 1'b1, 1'b0, 1'b1);
        tick();
        check_output("start7", 7, 1, 0, 0);
        apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 6; i >= 1; i--) begin
            tick();
            check_output("dec7", i, 1, 0, 0);
        end
        tick();
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        check_output("term7", 7, 1, 1, 0);
`else
        check_output("term7", 0, 0, 1, 1);
`endif
        apply_stimulus(1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        tick();
        check_output("load0_clears", 0, 0, 0, 0);

        // ce gating and stop mid-run.
        apply_stimulus(1'b1, 4'd4, 1'b0, 1'b0, 1'b0);
        tick();
        check_output("load4", 4, 0, 0, 0);
        apply_stimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        tick();
        check_output("start4", 4, 1, 0, 0);
        apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
        tick();
        check_output("ce1a", 3, 1, 0, 0);
        apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
        tick();
        check_output("ce0a", 3, 1, 0, 0);
        apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
        tick();
        check_output("ce1b", 2, 1, 0, 0);
        apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
        tick();
        check_output("ce0b", 2, 1, 0, 0);
        apply_stimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
        tick();
        check_output("stop_at2", 2, 0, 0, 0);
        apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
        tick();
        check_output("idle_ce", 2, 0, 0, 0);

        // load beats stop in RUN; start with count 0 is ignored.
        apply_stimulus(1'b1, 4'd6, 1'b0, 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        tick();
        check_output("start6", 6, 1, 0, 0);
        apply_stimulus(1'b1, 4'd3, 1'b0, 1'b1, 1'b1);
        tick();
        check_output("load_vs_stop", 3, 0, 0, 0);
        apply_stimulus(1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        tick();
        check_output("load_zero", 0, 0, 0, 0);
        apply_stimulus(1'b0, '0, 1'b1, 1'b0, 1'b1);
        tick();
        check_output("start_zero", 0, 0, 0, 0);
        tick();
        check_output("start_zero2", 0, 0, 0, 0);

        // Asynchronous reset mid-run at out=3.
        apply_stimulus(1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b0, '0, 1'b1, 1'b0, 1'b1);
        tick();
        apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        check_output("pre_reset", 3, 1, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_output("async_reset", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_output("post_reset1", 0, 0, 0, 0);
        tick();
        check_output("post_reset2", 0, 0, 0, 0);

        // Resume only after new load and start.
        apply_stimulus(1'b1, 4'd2, 1'b0, 1'b0, 1'b1);
        tick();
        check_output("reload2", 2, 0, 0, 0);
        apply_stimulus(1'b0, '0, 1'b1, 1'b0, 1'b1);
        tick();
        check_output("restart2", 2, 1, 0, 0);
        apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
        tick();
        check_output("dec2", 1, 1, 0, 0);
        tick();
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        check_output("term2", 2, 1, 1, 0);

        // Auto-reload from 3: tc every third cycle, done stays low, stop exits.
        apply_stimulus(1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
        tick();
        check_output("auto_load3", 3, 0, 0, 0);
        apply_stimulus(1'b0, '0, 1'b1, 1'b0, 1'b1);
        tick();
        check_output("auto_start3", 3, 1, 0, 0);
        apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int p = 0; p < 3; p++) begin
            tick();
            check_output("auto_a", 2, 1, 0, 0);
            tick();
            check_output("auto_b", 1, 1, 0, 0);
            tick();
            check_output("auto_tc", 3, 1, 1, 0);
        end
        apply_stimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);
        tick();
        check_output("auto_stop", 3, 0, 0, 0);
        apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
        tick();
        check_output("auto_stopped", 3, 0, 0, 0);
`else
        check_output("term2", 0, 0, 1, 1);
        tick();
        check_output("term2_hold", 0, 0, 0, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning modulus; loaded values are clamped to N-1.
REQ-002 The block SHALL have parameter WIDTH, default ceil(log2(N)), meaning count width.
REQ-003 The block SHALL have port clk  input  1  rising-edge clock; the block has a single clock domain.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port ce  input  1  count enable; it gates decrement only.
REQ-006 The block SHALL have port load  input  1  when high, captures load_val into count and into the reload register.
REQ-007 The block SHALL have port load_val  input  WIDTH  preload value.
REQ-008 The block SHALL have port start  input  1  request to begin counting.
REQ-009 The block SHALL have port stop  input  1  abort request.
REQ-010 The block SHALL have port out  output  WIDTH  current count.
REQ-011 The block SHALL have port busy  output  1  high while in RUN.
REQ-012 The block SHALL have port tc  output  1  one-cycle terminal-count pulse.
REQ-013 The block SHALL have port done  output  1  sticky completion flag.

Function
REQ-014 The FSM SHALL have three states, IDLE, RUN and DONE; all outputs are registered.
REQ-015 Input priority each cycle SHALL be load > stop > start > decrement.
REQ-016 On load, the block SHALL set count to min(load_val, N-1) and reload to the same value, go to IDLE, and clear done; load is legal in every state.
REQ-017 In IDLE, start SHALL move the FSM to RUN next cycle when count != 0; start with count == 0 SHALL be ignored, leaving the FSM in IDLE.
REQ-018 In RUN with ce=1 and count > 1, the block SHALL decrement count by 1; with ce=0, count SHALL hold.
REQ-019 In RUN with ce=1 and count == 1, the block SHALL set count to 0, pulse tc for exactly that next cycle, and go to DONE with done=1.
REQ-020 In RUN, stop SHALL return the FSM to IDLE, hold the count, leave done=0 and produce no tc.
REQ-021 In DONE, the FSM SHALL hold count 0 with done=1; start SHALL be ignored, because count is 0; stop SHALL go to IDLE and clear done.
REQ-022 busy SHALL be 1 exactly when state == RUN; tc SHALL never be high for 2 consecutive cycles unless the reload value is 1 under auto-reload.
REQ-023 Count arithmetic SHALL be WIDTH bits; the count SHALL never underflow or wrap below 0.

Reset
REQ-024 While rst_n=0, the block SHALL immediately force state=IDLE, out=0, reload=0, busy=0, tc=0 and done=0.
REQ-025 Reset asserted mid-RUN SHALL abort without a tc pulse; counting SHALL resume only after a new load and start.

Configuration
REQ-026 With COUNTDOWN_AUTO_RELOAD_EN defined, the block SHALL load count with reload and stay in RUN on a terminal count (REQ-019) while still pulsing tc; done SHALL stay 0; stop SHALL be the only exit.
REQ-027 Without COUNTDOWN_AUTO_RELOAD_EN, the block SHALL behave as one-shot per REQ-019, and the reload register MAY be omitted.

Structure
REQ-028 The package countdown_pkg SHALL hold the state encoding constants IDLE=2'd0, RUN=2'd1 and DONE=2'd2.
REQ-029 The block SHALL have one sub-module, countdown_core: the WIDTH-bit loadable, clamping, saturating-at-0 decrementer with zero/one detect; countdown_timer contains the FSM and flags.

Verification
REQ-030 The bench SHALL check that N=8, load_val=5, start, then ce=1 continuous give out 5,4,3,2,1,0, tc high for 1 cycle on 0, then done=1 and busy=0.
REQ-031 The bench SHALL check that load_val=12 with N=8 gives out=7, and that start then counts 7 down to 0 with tc after 7 enabled cycles.
REQ-032 The bench SHALL check that ce toggling 1,0,1,0 from 4 gives the sequence 3,3,2,2, and that stop at out=2 gives IDLE, out=2, no tc, done=0.
REQ-033 The bench SHALL check that load and stop asserted together in RUN result in load winning, out=load_val and state IDLE; start with out=0 leaves busy=0.
REQ-034 The bench SHALL check that rst_n pulled low asynchronously mid-RUN at out=3 gives out=0 and busy=0 before the next clk edge, with no tc.
REQ-035 The bench SHALL check that with COUNTDOWN_AUTO_RELOAD_EN and load_val=3, continuous ce gives a tc pulse every 3 cycles with done=0 throughout, and that stop ends the sequence.
